// File: rtl/sprite_compositor.sv
// sprite_compositor: N-layer sprite overlay on a VGA pixel stream.
// Layer geometry is latched once per frame. All layers share one pipelined
// pixel-memory port, and the background is delayed by the same 3 cycles.
// A green-object detector with frame hysteresis can hide selected layers.
module sprite_compositor #(
  parameter int N_SPR      = 4,
  parameter int SPR_W      = 200,
  parameter int SPR_H      = 200,
  parameter int X_START    = 216,
  parameter int Y_START    = 27,
  parameter int RADIUS_SQ  = 7400,
  parameter int DET_X      = 300,
  parameter int DET_Y      = 100,
  parameter int DET_THRESH = 5000,
  parameter int DET_ON     = 3,
  parameter int DET_OFF    = 3
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [9:0]          i_red,
  input  logic [9:0]          i_green,
  input  logic [9:0]          i_blue,
  input  logic [12:0]         i_h_count,
  input  logic [12:0]         i_v_count,
  input  logic [N_SPR-1:0]    i_spr_en,
  input  logic [N_SPR-1:0]    i_spr_round,
  input  logic [N_SPR-1:0]    i_spr_gate,
  input  logic [13*N_SPR-1:0] i_spr_x,
  input  logic [13*N_SPR-1:0] i_spr_y,
  input  logic [20*N_SPR-1:0] i_spr_base,
  output logic [19:0]         o_mem_addr,
  input  logic [31:0]         i_mem_data,
  output logic [9:0]          o_red,
  output logic [9:0]          o_green,
  output logic [9:0]          o_blue,
  output logic [3:0]          o_layer,
  output logic                o_detected,
  output logic [15:0]         o_det_count
);

  logic              refresh;
  logic [13:0]       h14;
  logic [13:0]       v14;
  logic [N_SPR-1:0]  sh_en;
  logic [N_SPR-1:0]  sh_round;
  logic [N_SPR-1:0]  sh_gate;
  logic [12:0]       sh_x    [N_SPR];
  logic [12:0]       sh_y    [N_SPR];
  logic [19:0]       sh_base [N_SPR];
  logic [N_SPR-1:0]  hit;
  logic [19:0]       layer_addr [N_SPR];
  logic              win_any;
  logic [3:0]        win_idx;
  logic [19:0]       win_addr;
  logic              s1_win;
  logic [3:0]        s1_idx;
  logic [29:0]       s1_bg;
  logic              s2_win;
  logic [3:0]        s2_idx;
  logic [29:0]       s2_bg;
  logic              in_det_win;
  logic              is_green;
  logic              hit_frame;
  logic [15:0]       green_count;
  logic [2:0]        on_cnt;
  logic [2:0]        off_cnt;
  logic [2:0]        on_next;
  logic [2:0]        off_next;
  logic [6:0]        unused_mem_bits;

  assign refresh         = (i_h_count == 13'd0) && (i_v_count == 13'd0);
  assign h14             = {1'b0, i_h_count};
  assign v14             = {1'b0, i_v_count};
  assign unused_mem_bits = i_mem_data[6:0];

  // Latch layer controls at refresh so geometry never changes mid-frame
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sh_en    <= '0;
      sh_round <= '0;
      sh_gate  <= '0;
      for (int k = 0; k < N_SPR; k++) begin
        sh_x[k]    <= '0;
        sh_y[k]    <= '0;
        sh_base[k] <= '0;
      end
    end else if (refresh) begin
      sh_en    <= i_spr_en;
      sh_round <= i_spr_round;
      sh_gate  <= i_spr_gate;
      for (int k = 0; k < N_SPR; k++) begin
        sh_x[k]    <= i_spr_x[13*k +: 13];
        sh_y[k]    <= i_spr_y[13*k +: 13];
        sh_base[k] <= i_spr_base[20*k +: 20];
      end
    end
  end

  // Per-layer hit test: rectangle, optional round mask, optional detect gate
  for (genvar k = 0; k < N_SPR; k++) begin : g_layer
    logic [13:0] left;
    logic [13:0] top;
    logic [13:0] cx;
    logic [13:0] cy;
    logic [7:0]  dx;
    logic [7:0]  dy;
    logic [16:0] dx_w;
    logic [16:0] dy_w;
    logic [16:0] sq;
    logic        in_rect;
    logic        mask_ok;
    logic        gate_ok;

    assign left    = 14'(X_START) + {1'b0, sh_x[k]};
    assign top     = 14'(Y_START) + {1'b0, sh_y[k]};
    assign cx      = left + 14'(SPR_W / 2);
    assign cy      = top + 14'(SPR_H / 2);
    assign in_rect = (h14 >= left) && (h14 < left + 14'(SPR_W)) &&
                     (v14 >= top) && (v14 < top + 14'(SPR_H));
    assign dx      = (h14 >= cx) ? 8'(h14 - cx) : 8'(cx - h14);
    assign dy      = (v14 >= cy) ? 8'(v14 - cy) : 8'(cy - v14);
    assign dx_w    = {9'd0, dx};
    assign dy_w    = {9'd0, dy};
    assign sq      = dx_w * dx_w + dy_w * dy_w;
    assign mask_ok = !sh_round[k] || (sq <= 17'(RADIUS_SQ));
    assign gate_ok = !sh_gate[k] || o_detected;
    assign hit[k]  = sh_en[k] && in_rect && mask_ok && gate_ok;
    assign layer_addr[k] = sh_base[k] + 20'(v14 - top) * 20'(SPR_W) + 20'(h14 - left);
  end

  // Lowest-index hit wins; transparency never falls through to lower layers
  always_comb begin
    win_any  = 1'b0;
    win_idx  = 4'hF;
    win_addr = '0;
    for (int k = N_SPR - 1; k >= 0; k--) begin
      if (hit[k]) begin
        win_any  = 1'b1;
        win_idx  = 4'(k);
        win_addr = layer_addr[k];
      end
    end
  end

  // Stage 1: issue the memory read; the address is held when nothing hits
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_addr <= '0;
      s1_win     <= 1'b0;
      s1_idx     <= 4'hF;
      s1_bg      <= '0;
    end else begin
      if (win_any)
        o_mem_addr <= win_addr;
      s1_win <= win_any;
      s1_idx <= win_idx;
      s1_bg  <= {i_red, i_green, i_blue};
    end
  end

  // Stage 2: carry winner and background while the memory read completes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_win <= 1'b0;
      s2_idx <= 4'hF;
      s2_bg  <= '0;
    end else begin
      s2_win <= s1_win;
      s2_idx <= s1_idx;
      s2_bg  <= s1_bg;
    end
  end

  // Stage 3: choose the opaque sprite texel or the delayed background
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_red   <= '0;
      o_green <= '0;
      o_blue  <= '0;
      o_layer <= 4'hF;
    end else begin
      if (s2_win && i_mem_data[7]) begin
        o_red   <= {i_mem_data[31:24], 2'b00};
        o_green <= {i_mem_data[23:16], 2'b00};
        o_blue  <= {i_mem_data[15:8], 2'b00};
      end else begin
        o_red   <= s2_bg[29:20];
        o_green <= s2_bg[19:10];
        o_blue  <= s2_bg[9:0];
      end
      o_layer <= s2_win ? s2_idx : 4'hF;
    end
  end

  assign in_det_win = (h14 >= 14'(X_START + DET_X)) && (h14 < 14'(X_START + DET_X + SPR_W)) &&
                      (v14 >= 14'(Y_START + DET_Y)) && (v14 < 14'(Y_START + DET_Y + SPR_H));
  assign is_green   = (i_green[9:2] >= 8'd80) && (i_red[9:2] < 8'd128) && (i_blue[9:2] < 8'd128);
  assign hit_frame  = green_count >= 16'(DET_THRESH);
  assign on_next    = hit_frame ? ((on_cnt == 3'd7) ? 3'd7 : on_cnt + 3'd1) : 3'd0;
  assign off_next   = hit_frame ? 3'd0 : ((off_cnt == 3'd7) ? 3'd7 : off_cnt + 3'd1);

  // Count green pixels in the detect window; publish and restart at refresh
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      green_count <= '0;
      o_det_count <= '0;
    end else if (refresh) begin
      o_det_count <= green_count;
      green_count <= '0;
    end else if (in_det_win && is_green && (green_count != 16'hFFFF)) begin
      green_count <= green_count + 16'd1;
    end
  end

  // Frame hysteresis: set after DET_ON hit frames, clear after DET_OFF misses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      on_cnt     <= '0;
      off_cnt    <= '0;
      o_detected <= 1'b0;
    end else if (refresh) begin
      on_cnt  <= on_next;
      off_cnt <= off_next;
      if (on_next >= 3'(DET_ON))
        o_detected <= 1'b1;
      else if (off_next >= 3'(DET_OFF))
        o_detected <= 1'b0;
    end
  end

endmodule
